// File: rtl/control_unit_v1_if.sv
// Instruction handshake between the fetch side and control_unit_v1.
// The fetch side drives the word and valid; the unit answers with ready.
interface control_unit_v1_if;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output instruction,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instruction,
    input  instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/control_unit_v1.sv
// Multi-cycle LEGv8-subset control unit driving the dataPath_V1 controls.
// Latches one instruction and sequences ALU, load and store operations.
module control_unit_v1 (
  input  logic               clock,
  input  logic               reset,
  control_unit_v1_if.slave   bus,
  output logic [63:0]        k,
  output logic [4:0]         FS,
  output logic               C0,
  output logic               B_Sel,
  output logic [4:0]         SA,
  output logic [4:0]         SB,
  output logic [4:0]         DA,
  output logic               EN_B,
  output logic               EN_ALU,
  output logic               EN_ADDR_ALU,
  output logic               ram_cs,
  output logic               ram_write_en,
  output logic               ram_read_en,
  output logic               w_reg,
  output logic               reset_reg,
  output logic               done,
  output logic               illegal
);

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_XOR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_OR  = 5'b01100;
  localparam logic [4:0] FS_SUB = 5'b01001;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [9:0]  OP_ANDI = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI = 10'b1011001000;
  localparam logic [8:0]  OP_MOVZ = 9'b110100101;

  typedef enum logic [2:0] {
    IDLE, EXEC, LD_ADDR, LD_WB, ST, ERR
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_MOVZ, C_LD, C_ST, C_BAD
  } cls_t;

  function automatic cls_t classify(input logic [31:0] w);
    cls_t c;
    c = C_BAD;
    if (w[31:21] == OP_ADD || w[31:21] == OP_SUB ||
        w[31:21] == OP_AND || w[31:21] == OP_ORR)
      c = C_R;
    else if (w[31:21] == OP_LDUR)
      c = C_LD;
    else if (w[31:21] == OP_STUR)
      c = C_ST;
    else if (w[31:22] == OP_ADDI || w[31:22] == OP_SUBI ||
             w[31:22] == OP_ANDI || w[31:22] == OP_ORRI)
      c = C_I;
    else if (w[31:23] == OP_MOVZ)
      c = C_MOVZ;
    return c;
  endfunction

  state_t      state, state_nxt;
  logic [31:0] ir;
  logic        armed;
  logic        accept;
  logic        w_raw;
  cls_t        ir_cls;

  // armed keeps ready low through the reset edge until reset is released
  assign accept = (state == IDLE) && armed && bus.instr_valid;
  assign reset_reg = ~reset;
  assign ir_cls = classify(ir);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      ir    <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (accept) ir <= bus.instruction;
    end
  end

  always_comb begin
    k     = '0;
    FS    = FS_AND;
    B_Sel = 1'b0;
    SA    = ir[9:5];
    SB    = ir[20:16];
    DA    = ir[4:0];
    unique case (ir_cls)
      C_R: begin
        if (ir[31:21] == OP_ADD)      FS = FS_ADD;
        else if (ir[31:21] == OP_SUB) FS = FS_SUB;
        else if (ir[31:21] == OP_ORR) FS = FS_OR;
        else                          FS = FS_AND;
      end
      C_I: begin
        B_Sel = 1'b1;
        k     = {52'd0, ir[21:10]};
        if (ir[31:22] == OP_ADDI)      FS = FS_ADD;
        else if (ir[31:22] == OP_SUBI) FS = FS_SUB;
        else if (ir[31:22] == OP_ORRI) FS = FS_OR;
        else                           FS = FS_AND;
      end
      C_LD, C_ST: begin
        B_Sel = 1'b1;
        FS    = FS_ADD;
        k     = {{55{ir[20]}}, ir[20:12]};
        if (ir_cls == C_ST) SB = ir[4:0];
      end
      C_MOVZ: begin
        B_Sel = 1'b1;
        FS    = FS_OR;
        SA    = 5'd31;
        k     = {48'd0, ir[20:5]} << {ir[22:21], 4'b0000};
      end
      default: FS = FS_AND;
    endcase
    C0 = (FS == FS_SUB);
  end

  always_comb begin
    state_nxt       = state;
    bus.instr_ready = 1'b0;
    EN_B            = 1'b0;
    EN_ALU          = 1'b0;
    EN_ADDR_ALU     = 1'b0;
    ram_cs          = 1'b0;
    ram_write_en    = 1'b0;
    ram_read_en     = 1'b0;
    w_raw           = 1'b0;
    done            = 1'b0;
    illegal         = 1'b0;
    unique case (state)
      IDLE: begin
        bus.instr_ready = armed;
        if (accept) begin
          unique case (classify(bus.instruction))
            C_R, C_I, C_MOVZ: state_nxt = EXEC;
            C_LD:             state_nxt = LD_ADDR;
            C_ST:             state_nxt = ST;
            default:          state_nxt = ERR;
          endcase
        end
      end
      EXEC: begin
        EN_ALU    = 1'b1;
        w_raw     = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      LD_ADDR: begin
        EN_ADDR_ALU = 1'b1;
        ram_cs      = 1'b1;
        ram_read_en = 1'b1;
        state_nxt   = LD_WB;
      end
      LD_WB: begin
        ram_cs      = 1'b1;
        ram_read_en = 1'b1;
        w_raw       = 1'b1;
        done        = 1'b1;
        state_nxt   = IDLE;
      end
      ST: begin
        EN_ADDR_ALU  = 1'b1;
        EN_B         = 1'b1;
        ram_cs       = 1'b1;
        ram_write_en = 1'b1;
        done         = 1'b1;
        state_nxt    = IDLE;
      end
      ERR: begin
        illegal   = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // writes to XZR are suppressed
  assign w_reg = w_raw && (DA != 5'd31);

endmodule

// File: tb/tb_control_unit_v1.sv
// Scoreboard bench for control_unit_v1: mnemonic-level model, random mix.
// Busy cycles are popped and compared by a negedge monitor.
module tb_control_unit_v1;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] k;
  logic [4:0]  FS, SA, SB, DA;
  logic        C0, B_Sel;
  logic        EN_B, EN_ALU, EN_ADDR_ALU;
  logic        ram_cs, ram_write_en, ram_read_en;
  logic        w_reg, reset_reg, done, illegal;

  control_unit_v1_if bus ();

  control_unit_v1 dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus.slave),
    .k            (k),
    .FS           (FS),
    .C0           (C0),
    .B_Sel        (B_Sel),
    .SA           (SA),
    .SB           (SB),
    .DA           (DA),
    .EN_B         (EN_B),
    .EN_ALU       (EN_ALU),
    .EN_ADDR_ALU  (EN_ADDR_ALU),
    .ram_cs       (ram_cs),
    .ram_write_en (ram_write_en),
    .ram_read_en  (ram_read_en),
    .w_reg        (w_reg),
    .reset_reg    (reset_reg),
    .done         (done),
    .illegal      (illegal)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [63:0] k;
    logic [4:0]  fs;
    logic        c0;
    logic        bsel;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [4:0]  da;
    logic        en_b;
    logic        en_alu;
    logic        en_addr;
    logic        cs;
    logic        we;
    logic        re;
    logic        wreg;
    logic        dn;
    logic        ill;
    logic        rdy;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_on = 0;
  bit   chk_rdy = 0;

  function automatic logic [31:0] enc_r(input logic [10:0] op,
      input logic [4:0] rm, input logic [4:0] rn, input logic [4:0] rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction

  function automatic logic [31:0] enc_i(input logic [9:0] op,
      input logic [11:0] imm, input logic [4:0] rn, input logic [4:0] rd);
    return {op, imm, rn, rd};
  endfunction

  function automatic logic [31:0] enc_d(input logic [10:0] op,
      input logic [8:0] imm, input logic [4:0] rn, input logic [4:0] rt);
    return {op, imm, 2'b00, rn, rt};
  endfunction

  function automatic logic [31:0] enc_m(input logic [1:0] hw,
      input logic [15:0] imm, input logic [4:0] rd);
    return {9'b110100101, hw, imm, rd};
  endfunction

  // Expected busy-cycle sequence for one instruction, from its mnemonic
  function automatic void model(input logic [31:0] w, input bit abandon);
    string  m;
    exp_t   e, a;
    longint off;
    m = "BAD";
    case (w[31:21])
      11'b10001011000: m = "ADD";
      11'b11001011000: m = "SUB";
      11'b10001010000: m = "AND";
      11'b10101010000: m = "ORR";
      11'b11111000010: m = "LDUR";
      11'b11111000000: m = "STUR";
      default: begin
        case (w[31:22])
          10'b1001000100: m = "ADDI";
          10'b1101000100: m = "SUBI";
          10'b1001001000: m = "ANDI";
          10'b1011001000: m = "ORRI";
          default: if (w[31:23] == 9'b110100101) m = "MOVZ";
        endcase
      end
    endcase
    e = '0;
    e.sa = w[9:5];
    e.sb = w[20:16];
    e.da = w[4:0];
    off = $signed(w[20:12]);
    case (m)
      "ADD":  e.fs = 5'b01000;
      "SUB":  begin e.fs = 5'b01001; e.c0 = 1; end
      "AND":  e.fs = 5'b00000;
      "ORR":  e.fs = 5'b01100;
      "ADDI": begin e.fs = 5'b01000; e.bsel = 1; e.k = 64'(w[21:10]); end
      "SUBI": begin e.fs = 5'b01001; e.c0 = 1; e.bsel = 1; e.k = 64'(w[21:10]); end
      "ANDI": begin e.fs = 5'b00000; e.bsel = 1; e.k = 64'(w[21:10]); end
      "ORRI": begin e.fs = 5'b01100; e.bsel = 1; e.k = 64'(w[21:10]); end
      "LDUR", "STUR": begin
        e.fs = 5'b01000;
        e.bsel = 1;
        e.k = off;
        if (m == "STUR") e.sb = w[4:0];
      end
      "MOVZ": begin
        e.fs = 5'b01100;
        e.bsel = 1;
        e.sa = 5'd31;
        e.k = 64'(w[20:5]) * (64'd1 << (16 * w[22:21]));
      end
      default: e.fs = 5'b00000;
    endcase
    if (m == "LDUR") begin
      a = e; a.en_addr = 1; a.cs = 1; a.re = 1;
      q.push_back(a);
      if (!abandon) begin
        a = e; a.cs = 1; a.re = 1; a.wreg = (e.da != 31); a.dn = 1;
        q.push_back(a);
      end
    end else if (m == "STUR") begin
      a = e; a.en_addr = 1; a.en_b = 1; a.cs = 1; a.we = 1; a.dn = 1;
      q.push_back(a);
    end else if (m == "BAD") begin
      a = e; a.ill = 1; a.dn = 1;
      q.push_back(a);
    end else begin
      a = e; a.en_alu = 1; a.wreg = (e.da != 31); a.dn = 1;
      q.push_back(a);
    end
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
      input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t act, e;
    if (mon_on) begin
      act = {k, FS, C0, B_Sel, SA, SB, DA, EN_B, EN_ALU, EN_ADDR_ALU,
             ram_cs, ram_write_en, ram_read_en, w_reg, done, illegal,
             bus.instr_ready};
      if (chk_rdy) begin
        chk_rdy = 0;
        total++;
        if (bus.instr_ready !== 1'b1) begin
          bad++;
          $display("FAIL ready_after_done: got %b want 1", bus.instr_ready);
        end
      end
      if (EN_B | EN_ALU | EN_ADDR_ALU | ram_cs | w_reg | done | illegal) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_busy: got %h want none", act);
        end else begin
          e = q.pop_front();
          if (act !== e) begin
            bad++;
            $display("FAIL busy_cycle: got %h want %h", act, e);
          end
          if (e.dn) chk_rdy = 1;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge of the first busy cycle
  task automatic issue(input logic [31:0] w, input bit abandon);
    int n;
    n = 0;
    bus.instr_valid = 1'b1;
    while (!bus.instr_ready && n < 20) begin
      bus.instruction = $urandom;
      @(negedge clock);
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: got ready=0 want ready=1");
    end else begin
      bus.instruction = w;
      model(w, abandon);
      @(posedge clock);
      #1 bus.instruction = $urandom;
      @(negedge clock);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [10:0] r_ops[4];
    logic [9:0]  i_ops[4];
    logic [4:0]  rd;
    r_ops = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
    i_ops = '{10'b1001000100, 10'b1101000100, 10'b1001001000, 10'b1011001000};
    rd = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom);
    case ($urandom_range(0, 5))
      0: return {r_ops[$urandom_range(0, 3)], 5'($urandom), 6'($urandom),
                 5'($urandom), rd};
      1: return enc_i(i_ops[$urandom_range(0, 3)], 12'($urandom),
                      5'($urandom), rd);
      2: return enc_m(2'($urandom), 16'($urandom), rd);
      3: return enc_d(11'b11111000010, 9'($urandom), 5'($urandom), rd);
      4: return enc_d(11'b11111000000, 9'($urandom), 5'($urandom), rd);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instruction = enc_i(10'b1001000100, 12'd5, 5'd1, 5'd2);
    repeat (3) begin
      @(posedge clock);
      @(negedge clock);
      chk("rst_ready", 64'(bus.instr_ready), 64'd0);
      chk("rst_enables", 64'({EN_B, EN_ALU, EN_ADDR_ALU, ram_cs,
          ram_write_en, ram_read_en, w_reg, done, illegal}), 64'd0);
      chk("rst_reset_reg", 64'(reset_reg), 64'd1);
    end
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("release_ready", 64'(bus.instr_ready), 64'd1);
    chk("release_reset_reg", 64'(reset_reg), 64'd0);
    mon_on = 1;

    issue(enc_i(10'b1011001000, 12'd10, 5'd31, 5'd0), 0);
    chk("orri_k", k, 64'd10);
    chk("orri_sa", 64'(SA), 64'd31);
    bus.instr_valid = 1'b0;
    @(negedge clock);
    issue(enc_r(11'b11001011000, 5'd2, 5'd1, 5'd3), 0);
    chk("sub_fs_c0", 64'({FS, C0}), 64'({5'b01001, 1'b1}));
    issue(enc_r(11'b10001011000, 5'd2, 5'd1, 5'd31), 0);
    chk("add_xzr_wreg", 64'({EN_ALU, w_reg}), 64'({1'b1, 1'b0}));
    issue(enc_d(11'b11111000010, 9'h1F8, 5'd2, 5'd5), 0);
    chk("ldur_k", k, 64'hFFFF_FFFF_FFFF_FFF8);
    issue(enc_d(11'b11111000000, 9'd16, 5'd1, 5'd7), 0);
    chk("stur_sb", 64'(SB), 64'd7);
    issue(32'h0000_0000, 0);
    chk("illegal_pulse", 64'(illegal), 64'd1);
    issue(enc_m(2'd2, 16'hBEEF, 5'd4), 0);
    chk("movz_k", k, 64'h0000_BEEF_0000_0000);
    bus.instr_valid = 1'b0;
    @(negedge clock);

    issue(enc_d(11'b11111000010, 9'd8, 5'd3, 5'd6), 1);
    reset = 1'b0;
    bus.instr_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("abandon_strobes", 64'({w_reg, ram_cs, ram_read_en, done}), 64'd0);
    chk("abandon_ready", 64'(bus.instr_ready), 64'd0);
    chk("abandon_reset_reg", 64'(reset_reg), 64'd1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("abandon_idle", 64'({bus.instr_ready, EN_ALU, ram_cs, w_reg}),
        64'({1'b1, 3'b000}));
    chk("abandon_ir_cleared", k, 64'd0);

    for (int i = 0; i < 300; i++) begin
      issue(rand_instr(), 0);
      if ($urandom_range(0, 2) == 0) begin
        bus.instr_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clock);
      end
    end
    bus.instr_valid = 1'b0;
    repeat (5) @(negedge clock);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit_v1.md
# control_unit_v1

Multi-cycle control unit that sits directly upstream of `dataPath_V1`. It accepts one 32-bit LEGv8-subset instruction at a time over a valid/ready handshake and drives every datapath control input for the instruction's duration: k, FS, B_Sel, SA, SB, DA, C0, the bus enables, the RAM strobes and the register-file write and reset. It holds the instruction in an internal register and sequences ALU, load and store instructions through a small state machine.

## Interface
- No parameters. All widths are fixed to match `dataPath_V1`.
- `clock` input 1: the single clock. Everything samples on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `instruction` input 32: the instruction word. It is sampled only on an accepted handshake.
- `instr_valid` input 1: the upstream side presents an instruction.
- `instr_ready` output 1: the unit can accept an instruction this cycle.
- `k` output 64: immediate value presented to the datapath B mux.
- `FS` output 5: ALU function select.
- `C0` output 1: ALU carry-in.
- `B_Sel` output 1: 1 selects `k`, 0 selects register B.
- `SA`, `SB`, `DA` output 5 each: read port A, read port B and write-address selects.
- `EN_B`, `EN_ALU`, `EN_ADDR_ALU` output 1 each: bus and address drive enables.
- `ram_cs`, `ram_write_en`, `ram_read_en` output 1 each: RAM strobes.
- `w_reg` output 1: register-file write enable.
- `reset_reg` output 1: register-file reset, driven as the inverse of `reset`.
- `done` output 1: one-cycle pulse in the final cycle of every instruction.
- `illegal` output 1: one-cycle pulse when the latched opcode is unsupported.

## Operation
- **Registers:** state and a 32-bit instruction register `IR`. All control outputs are decoded combinationally from state and `IR` only. No input feeds an output combinationally except `reset` into `reset_reg`.
- **FS codes:** AND=00000, XOR=00100, ADD=01000, OR=01100, SUB=01001. SUB also sets C0=1. C0=0 for every other code.
- **Supported opcodes, R-type:**
  - ADD `10001011000`, SUB `11001011000`, AND `10001010000`, ORR `10101010000`.
  - Field mapping: SA=IR[9:5], SB=IR[20:16], DA=IR[4:0], B_Sel=0.
- **Supported opcodes, I-type:**
  - ADDI `1001000100`, SUBI `1101000100`, ANDI `1001001000`, ORRI `1011001000`.
  - Field mapping: k = zero-extended IR[21:10], B_Sel=1.
- **Supported opcodes, D-type:**
  - LDUR `11111000010`, STUR `11111000000`.
  - Field mapping: k = sign-extended IR[20:12] (9 bits to 64), FS=ADD, SA=IR[9:5].
- **Supported opcodes, MOVZ `110100101`:**
  - k = zero-extended IR[20:5] shifted left by 16×IR[22:21].
  - SA=31, FS=OR, B_Sel=1, DA=IR[4:0].
- **Decode priority:** match the 11-bit opcodes first, then the 10-bit, then the 9-bit.
- **States:**
  - IDLE: `instr_ready`=1 and all enables 0. On `instr_valid`=1: load `IR` and go to EXEC, LD_ADDR, ST or ERR according to the opcode.
  - EXEC: EN_ALU=1, w_reg=1, done=1, then IDLE.
  - LD_ADDR: EN_ADDR_ALU=1, ram_cs=1, ram_read_en=1, then LD_WB.
  - LD_WB: ram_cs=1, ram_read_en=1, w_reg=1, DA=IR[4:0], done=1, then IDLE.
  - ST: EN_ADDR_ALU=1, EN_B=1, SB=IR[4:0], ram_cs=1, ram_write_en=1, done=1, then IDLE.
  - ERR: illegal=1, done=1, all enables 0, then IDLE.
- **XZR writes:** when DA=31, w_reg is forced to 0. Every other output behaves as normal.
- **Mutual exclusion:** EN_ALU and EN_B are never both 1. ram_write_en and ram_read_en are never both 1.
- **Outputs outside their states:** k, FS, SA, SB and DA show the decode of `IR` in every state. Only the enables and strobes are state-gated.

## Timing
- **Reset:**
  - Takes effect on the rising edge where `reset`=0.
  - After that edge: state=IDLE, `IR`=0, all enables, strobes, `done` and `illegal` are 0.
  - `instr_ready` is 0 while `reset`=0, and 1 in the first cycle after release.
  - `reset_reg`=1 whenever `reset`=0.
- **Reset mid-instruction:** the instruction is abandoned. No further `w_reg` or RAM strobe is issued.
- **Latency, instruction accepted at edge N:**
  - ALU and MOVZ: EXEC occupies cycle N..N+1, register written at edge N+1, `instr_ready`=1 again after N+1.
  - LDUR: LD_ADDR, then LD_WB. The register is written at edge N+2.
  - STUR and illegal opcodes: one cycle, same as ALU.
- **Back-pressure:** `instr_ready` is 0 in every non-IDLE state. The upstream side must hold `instruction` and `instr_valid` until it sees `instr_ready`=1. `instruction` is ignored whenever `instr_ready`=0.
- **Back-to-back issue:** an instruction presented in the cycle after `done` is accepted with no bubble beyond IDLE. Throughput is 1 instruction per 2 cycles for ALU and store, and per 3 cycles for loads.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with `instr_valid`=1 → `instr_ready`=0, all enables 0, `reset_reg`=1. After release, `instr_ready`=1.
- **ORRI:** ORRI X0, XZR, #10 → EXEC with SA=31, B_Sel=1, k=10, FS=01100, DA=0, w_reg=1, EN_ALU=1, done=1. `instr_ready` returns 1 the next cycle.
- **SUB:** SUB X3, X1, X2 → SA=1, SB=2, DA=3, FS=01001, C0=1, B_Sel=0.
- **ADD to XZR:** ADD X31, X1, X2 → EN_ALU=1 but w_reg=0.
- **LDUR, negative offset:** LDUR X5, [X2, #-8] → k=0xFFFF_FFFF_FFFF_FFF8.
  - LD_ADDR cycle: EN_ADDR_ALU=1, ram_read_en=1.
  - LD_WB cycle: w_reg=1, DA=5.
  - Total 2 busy cycles.
- **STUR:** STUR X7, [X1, #16] → ST cycle with EN_B=1, SB=7, ram_write_en=1, ram_read_en=0, w_reg=0.
- **Illegal opcode:** opcode 0x000 → `illegal` pulses 1 cycle, no enables asserted.
- **Reset abandons a load:** assert reset during LD_ADDR → no LD_WB write follows, and the next state is IDLE.
- **MOVZ:** MOVZ X4, #0xBEEF, LSL #32 → k=0x0000_BEEF_0000_0000.
- **Handshake hold-off:** `instr_valid` held at 1 during a load → the second instruction is latched only on the edge where `instr_ready`=1.
